// File: rtl/z80_bus_mem_ctrl.sv
// ---------------------------------------------------------------------------
// z80_bus_mem_ctrl
// Z80 bus slave for tv80-family cores: byte RAM, I/O register file,
// programmable wait-state insertion, interrupt-acknowledge vector and a
// write-trace FIFO.  The bench loader writes RAM through a side port that
// only gets a slot while the bus is idle.
//
// Optional feature macro: TRACE_READS_EN
//   defined   - completed MEM/IO reads are also pushed into the trace FIFO
//   undefined - only committed writes are traced (is_write always 1)
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   A, cpu_do, cpu_di     CPU address, write data, registered read data
//   mreq_n, iorq_n        memory / I/O request
//   rd_n, wr_n            read / write strobes
//   m1_n, rfsh_n          opcode-fetch/int-ack and refresh qualifiers
//   wait_n                registered wait request to the CPU
//   ld_we/addr/data/ack   loader RAM write port, ack = accepted this cycle
//   trace_valid/ready     trace FIFO handshake: an entry moves when both are
//                         high at a rising edge; trace_data is stable and
//                         valid whenever trace_valid is high
//   trace_data            {is_io, is_write, addr[15:0], data[7:0]} at head
//   trace_ovf             sticky: a push was dropped because FIFO was full
//   dbg_state             current bus FSM state (0 idle, 1 wait, 2 done)
// ---------------------------------------------------------------------------
module z80_bus_mem_ctrl #(
  parameter int         MEM_AW      = 16,
  parameter int         IO_AW       = 8,
  parameter int         MEM_WS      = 0,
  parameter int         IO_WS       = 1,
  parameter logic [7:0] ACK_VECTOR  = 8'hFF,
  parameter int         TRACE_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       A,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              rfsh_n,
  output logic              wait_n,
  input  logic              ld_we,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [25:0]       trace_data,
  output logic              trace_ovf,
  output logic [1:0]        dbg_state
);

  localparam int         TAW      = $clog2(TRACE_DEPTH);
  localparam logic [3:0] MEM_WS_L = 4'(MEM_WS);
  localparam logic [3:0] IO_WS_L  = 4'(IO_WS);
  localparam logic [TAW:0] DEPTH_L = (TAW+1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] ws_sel;
  logic       is_io_q, is_io_d;
  logic       is_inta_q, is_inta_d;
  logic       wr_done_q, wr_done_d;
  logic       wait_n_q, wait_n_d;
  logic [7:0] cpu_di_q;

  logic       mem_acc, io_acc, inta_acc, any_acc;
  logic       wr_fire;
  logic [7:0] rd_value;

  logic [7:0] mem_q [2**MEM_AW];
  logic [7:0] io_q  [2**IO_AW];

  // Refresh cycles (mreq_n low with rfsh_n low) fall out of every class.
  assign mem_acc  = !mreq_n && rfsh_n;
  assign io_acc   = !iorq_n && m1_n;
  assign inta_acc = !iorq_n && !m1_n;
  assign any_acc  = mem_acc || io_acc || inta_acc;

  assign rd_value = is_io_q ? io_q[A[IO_AW-1:0]] : mem_q[A[MEM_AW-1:0]];

`ifdef TRACE_READS_EN
  logic rd_done_q, rd_done_d;
  logic rd_fire;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_io_d   = is_io_q;
    is_inta_d = is_inta_q;
    wr_done_d = wr_done_q;
    wait_n_d  = 1'b1;
    ws_sel    = mem_acc ? MEM_WS_L : IO_WS_L;
    wr_fire   = 1'b0;
`ifdef TRACE_READS_EN
    rd_done_d = rd_done_q;
    rd_fire   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        wr_done_d = 1'b0;
`ifdef TRACE_READS_EN
        rd_done_d = 1'b0;
`endif
        if (inta_acc) begin
          state_d   = S_DONE;
          is_io_d   = 1'b0;
          is_inta_d = 1'b1;
        end else if (mem_acc || io_acc) begin
          is_io_d   = !mem_acc;
          is_inta_d = 1'b0;
          if (ws_sel != 4'd0) begin
            // wait_n drops on this edge so it is low for exactly WS cycles
            state_d  = S_WAIT;
            cnt_d    = ws_sel - 4'd1;
            wait_n_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          wait_n_d = 1'b0;
        end
      end
      S_DONE: begin
        // One write per access no matter how long wr_n stays low.
        if (!is_inta_q && !wr_n && !wr_done_q) begin
          wr_fire   = reset_n;
          wr_done_d = 1'b1;
        end
`ifdef TRACE_READS_EN
        if (!is_inta_q && !rd_n && !rd_done_q) begin
          rd_fire   = reset_n;
          rd_done_d = 1'b1;
        end
`endif
        if (mreq_n && iorq_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      is_io_q   <= 1'b0;
      is_inta_q <= 1'b0;
      wr_done_q <= 1'b0;
      wait_n_q  <= 1'b1;
      cpu_di_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_io_q   <= is_io_d;
      is_inta_q <= is_inta_d;
      wr_done_q <= wr_done_d;
      wait_n_q  <= wait_n_d;
      if (state_q == S_DONE) begin
        if (is_inta_q)  cpu_di_q <= ACK_VECTOR;
        else if (!rd_n) cpu_di_q <= rd_value;
      end
    end
  end

`ifdef TRACE_READS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) rd_done_q <= 1'b0;
    else          rd_done_q <= rd_done_d;
  end
`endif

  // Loader only gets the RAM port when the bus is quiet.
  assign ld_ack = reset_n && ld_we && (state_q == S_IDLE) && !any_acc;

  always_ff @(posedge clk) begin
    if (ld_ack)
      mem_q[ld_addr] <= ld_data;
    else if (wr_fire && !is_io_q)
      mem_q[A[MEM_AW-1:0]] <= cpu_do;
    if (wr_fire && is_io_q)
      io_q[A[IO_AW-1:0]] <= cpu_do;
  end

  // Trace FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [25:0] fifo_q [TRACE_DEPTH];
  logic [TAW:0] wp_q, rp_q;
  logic         push, pop, full, ovf_q;
  logic [25:0]  push_data;

`ifdef TRACE_READS_EN
  assign push      = wr_fire || rd_fire;
  assign push_data = wr_fire ? {is_io_q, 1'b1, A, cpu_do}
                             : {is_io_q, 1'b0, A, rd_value};
`else
  assign push      = wr_fire;
  assign push_data = {is_io_q, 1'b1, A, cpu_do};
`endif

  assign full        = (wp_q - rp_q) == DEPTH_L;
  assign trace_valid = wp_q != rp_q;
  assign pop         = trace_valid && trace_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (push && (!full || pop)) wp_q  <= wp_q + 1'b1;
      else if (push)              ovf_q <= 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && (!full || pop)) fifo_q[wp_q[TAW-1:0]] <= push_data;
  end

  assign trace_data = fifo_q[rp_q[TAW-1:0]];
  assign trace_ovf  = ovf_q;
  assign cpu_di     = cpu_di_q;
  assign wait_n     = wait_n_q;
  assign dbg_state  = state_q;

endmodule
